// File: rtl/main_op_seq_pkg.sv
// main_op_seq_pkg: shared types and widths for the main operation sequencer.
package main_op_seq_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_BUSY, WAIT_DONE, RESP} state_e;
    localparam logic [1:0] ON_OFF = 2'd0;
    localparam int X_W  = 8;
    localparam int ON_W = 2;
    localparam int S_W  = 3;
endpackage

// File: rtl/main_op_seq_watchdog.sv
// main_op_seq_watchdog: counts wait cycles and flags expiry on the TIMEOUT-th one.
module main_op_seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/main_op_sequencer.sv
// main_op_sequencer: drives main's x/on/start sequence for one host request and returns y/s via valid/ready.
// Optional watchdog abort is compiled in with MAIN_OP_SEQ_WATCHDOG_EN.
module main_op_sequencer
    import main_op_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [X_W-1:0]  req_x,
    input  logic [ON_W-1:0] req_on,
    output logic            req_ready,
    output logic [X_W-1:0]  m_x,
    output logic [ON_W-1:0] m_on,
    output logic            m_start,
    input  logic            m_b,
    input  logic [X_W-1:0]  m_y,
    input  logic [S_W-1:0]  m_s,
    output logic            rsp_valid,
    output logic [X_W-1:0]  rsp_y,
    output logic [S_W-1:0]  rsp_s,
    output logic            rsp_err,
    input  logic            rsp_ready
);
    state_e          state_q, state_d;
    logic [X_W-1:0]  x_q, x_d, y_q, y_d;
    logic [ON_W-1:0] on_q, on_d;
    logic [S_W-1:0]  s_q, s_d;
    logic            err_q, err_d;
    logic            wd_expired;

`ifdef MAIN_OP_SEQ_WATCHDOG_EN
    main_op_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == STROBE),
        .en      (state_q == WAIT_BUSY || state_q == WAIT_DONE),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        on_d    = on_q;
        y_d     = y_q;
        s_d     = s_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                x_d     = req_x;
                on_d    = req_on;
                state_d = SETUP;
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = WAIT_BUSY;
            WAIT_BUSY: if (m_b) state_d = WAIT_DONE;
                else if (wd_expired) begin
                    state_d = RESP;
                    {y_d, s_d, err_d} = {{X_W{1'b0}}, {S_W{1'b0}}, 1'b1};
                end
            WAIT_DONE: if (!m_b) begin
                    state_d = RESP;
                    {y_d, s_d, err_d} = {m_y, m_s, 1'b0};
                end else if (wd_expired) begin
                    state_d = RESP;
                    {y_d, s_d, err_d} = {{X_W{1'b0}}, {S_W{1'b0}}, 1'b1};
                end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            on_q    <= ON_OFF;
            y_q     <= '0;
            s_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            on_q    <= on_d;
            y_q     <= y_d;
            s_q     <= s_d;
            err_q   <= err_d;
        end
    end

    // main only sees a mode while an operation is in flight
    assign m_on      = (state_q inside {SETUP, STROBE, WAIT_BUSY, WAIT_DONE}) ? on_q : ON_OFF;
    assign m_x       = x_q;
    assign m_start   = (state_q == STROBE);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_y     = y_q;
    assign rsp_s     = s_q;
    assign rsp_err   = err_q;
endmodule
